// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared fclass bit indices, constants and types for the FP operand stage
package fp_pkg;

    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;

    typedef logic [9:0] fclass_t;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational RISC-V fclass one-hot of an IEEE-754 single
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] opnd,
    output fclass_t     cls
);

    logic        sign;
    logic [7:0]  expo;
    logic [22:0] man;

    assign sign = opnd[31];
    assign expo = opnd[30:23];
    assign man  = opnd[22:0];

    always_comb begin
        cls = '0;
        if (expo == FP_EXP_MAX) begin
            if (man == '0)
                cls[sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            else
                cls[man[22] ? CLS_QNAN : CLS_SNAN] = 1'b1;
        end else if (expo == 8'h00) begin
            if (man == '0)
                cls[sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
            else
                cls[sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
        end else begin
            cls[sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_operand_stage.sv
// rtl/fp_operand_stage.sv - classify FP operands at issue and buffer them in a skid FIFO
// Optional FP_OPND_CANON_NAN_EN: store NaN operands as the canonical quiet NaN.
module fp_operand_stage
    import fp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OP_W  = 3,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  out_op,
    output logic [31:0]      out_rs1,
    output logic [31:0]      out_rs2,
    output logic [TAG_W-1:0] out_rd,
    output logic [9:0]       out_cls1,
    output logic [9:0]       out_cls2,
    output logic             out_snan,
    output logic             out_nan2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             resetn_q;

    logic [OP_W-1:0]  mem_op   [DEPTH];
    logic [31:0]      mem_rs1  [DEPTH];
    logic [31:0]      mem_rs2  [DEPTH];
    logic [TAG_W-1:0] mem_rd   [DEPTH];
    fclass_t          mem_cls1 [DEPTH];
    fclass_t          mem_cls2 [DEPTH];

    fclass_t     cls1_in, cls2_in;
    logic [31:0] rs1_st, rs2_st;
    logic        wr_en, rd_en;

    fp_classify u_cls1 (.opnd(in_rs1), .cls(cls1_in));
    fp_classify u_cls2 (.opnd(in_rs2), .cls(cls2_in));

`ifdef FP_OPND_CANON_NAN_EN
    assign rs1_st = (cls1_in[CLS_SNAN] | cls1_in[CLS_QNAN]) ? FP_CANON_NAN : in_rs1;
    assign rs2_st = (cls2_in[CLS_SNAN] | cls2_in[CLS_QNAN]) ? FP_CANON_NAN : in_rs2;
`else
    assign rs1_st = in_rs1;
    assign rs2_st = in_rs2;
`endif

    // in_ready is purely registered so upstream timing never sees out_ready
    assign in_ready  = resetn_q & (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign wr_en     = in_valid & in_ready;
    assign rd_en     = out_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resetn_q <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_op[i]   <= '0;
                mem_rs1[i]  <= '0;
                mem_rs2[i]  <= '0;
                mem_rd[i]   <= '0;
                mem_cls1[i] <= '0;
                mem_cls2[i] <= '0;
            end
        end else begin
            resetn_q <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) begin
                    mem_op[wr_ptr]   <= in_op;
                    mem_rs1[wr_ptr]  <= rs1_st;
                    mem_rs2[wr_ptr]  <= rs2_st;
                    mem_rd[wr_ptr]   <= in_rd;
                    mem_cls1[wr_ptr] <= cls1_in;
                    mem_cls2[wr_ptr] <= cls2_in;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (rd_en)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (wr_en && !rd_en)
                    count <= count + CNT_W'(1);
                else if (rd_en && !wr_en)
                    count <= count - CNT_W'(1);
            end
        end
    end

    assign out_op   = mem_op[rd_ptr];
    assign out_rs1  = mem_rs1[rd_ptr];
    assign out_rs2  = mem_rs2[rd_ptr];
    assign out_rd   = mem_rd[rd_ptr];
    assign out_cls1 = mem_cls1[rd_ptr];
    assign out_cls2 = mem_cls2[rd_ptr];
    assign out_snan = out_cls1[CLS_SNAN] | out_cls2[CLS_SNAN];
    assign out_nan2 = (out_cls1[CLS_SNAN] | out_cls1[CLS_QNAN]) &
                      (out_cls2[CLS_SNAN] | out_cls2[CLS_QNAN]);

endmodule

// File: tb/tb_fp_operand_stage.sv
// tb/tb_fp_operand_stage.sv - randomized self-checking bench for fp_operand_stage
`timescale 1ns/1ps
module tb_fp_operand_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_snan, out_nan2;
    logic [2:0]  in_op, out_op;
    logic [31:0] in_rs1, in_rs2, out_rs1, out_rs2;
    logic [4:0]  in_rd, out_rd;
    logic [9:0]  out_cls1, out_cls2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_operand_stage #(.DEPTH(DEPTH), .OP_W(3), .TAG_W(5)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_cls1(out_cls1), .out_cls2(out_cls2),
        .out_snan(out_snan), .out_nan2(out_nan2)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];
    logic rq = 1'b0;

    function automatic logic [9:0] cls_of(input logic [31:0] x);
        int idx;
        logic s;
        s = x[31];
        if (x[30:23] == 8'd255)
            idx = (x[22:0] == 0) ? (s ? 0 : 7) : (x[22] ? 9 : 8);
        else if (x[30:23] == 8'd0)
            idx = (x[22:0] == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
        else
            idx = s ? 1 : 6;
        return 10'd1 << idx;
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'd255) && (x[22:0] != 0);
    endfunction

    function automatic logic [31:0] stored(input logic [31:0] x);
`ifdef FP_OPND_CANON_NAN_EN
        if (is_nan(x)) return 32'h7FC00000;
`endif
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted ops
    always @(negedge resetn) begin
        q.delete();
        rq = 1'b0;
    end

    always @(posedge clk) begin
        if (resetn) begin
            logic rdy, acc, pop;
            rdy = rq && (q.size() != DEPTH);
            acc = in_valid && rdy;
            pop = (q.size() != 0) && out_ready;
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back('{in_op, in_rs1, in_rs2, in_rd});
            end
            rq = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, rq && (q.size() != DEPTH)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                ent_t e;
                e = q[0];
                chk("out_op", {29'd0, out_op}, {29'd0, e.op});
                chk("out_rs1", out_rs1, stored(e.a));
                chk("out_rs2", out_rs2, stored(e.b));
                chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("out_cls1", {22'd0, out_cls1}, {22'd0, cls_of(e.a)});
                chk("out_cls2", {22'd0, out_cls2}, {22'd0, cls_of(e.b)});
                chk("out_snan", {31'd0, out_snan},
                    {31'd0, (is_nan(e.a) && !e.a[22]) || (is_nan(e.b) && !e.b[22])});
                chk("out_nan2", {31'd0, out_nan2}, {31'd0, is_nan(e.a) && is_nan(e.b)});
            end
        end
    end

    task automatic push1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] tbl [8];
        logic [31:0] r;
        tbl = '{32'h7F800001, 32'h7FC00000, 32'h7F800000, 32'hFF800000,
                32'h00000000, 32'h80000000, 32'h00000001, 32'h807FFFFF};
        r = $urandom;
        if ($urandom_range(0, 1) == 0) r = tbl[$urandom_range(0, 7)];
        return r;
    endfunction

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("t1_ready_pre", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_ready_post", {31'd0, in_ready}, 32'd1);
        chk("t1_valid", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b1;
        push1(3'd1, 32'h3F800000, 32'hFF800000, 5'd7);
        @(negedge clk);
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_cls1", {22'd0, out_cls1}, 32'h040);
        chk("t2_cls2", {22'd0, out_cls2}, 32'h001);
        chk("t2_snan", {31'd0, out_snan}, 32'd0);
        @(posedge clk); #1;

        push1(3'd2, 32'h7F800001, 32'h7FC00000, 5'd8);
        @(negedge clk);
        chk("t3_cls1", {22'd0, out_cls1}, 32'h100);
        chk("t3_cls2", {22'd0, out_cls2}, 32'h200);
        chk("t3_snan", {31'd0, out_snan}, 32'd1);
        chk("t3_nan2", {31'd0, out_nan2}, 32'd1);
`ifdef FP_OPND_CANON_NAN_EN
        chk("t3_rs1", out_rs1, 32'h7FC00000);
`else
        chk("t3_rs1", out_rs1, 32'h7F800001);
`endif
        @(posedge clk); #1;

        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd3; in_rs1 = 32'h40000000; in_rs2 = 32'h00000001; in_rd = 5'd1;
        @(posedge clk); #1 in_rd = 5'd2;
        @(posedge clk); #1 in_rd = 5'd3;
        @(negedge clk);
        chk("t4_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t4_rd1", {27'd0, out_rd}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_rd2", {27'd0, out_rd}, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_empty", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        push1(3'd4, 32'hBF800000, 32'h3F000000, 5'd9);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_rd = 5'(10 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("t5_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_head", {27'd0, out_rd}, 32'd19);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);

        push1(3'd5, 32'h3F800000, 32'h3F800000, 5'd20);
        @(negedge clk);
        chk("t6_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; in_valid = 1'b1; in_rd = 5'd30;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_ready", {31'd0, in_ready}, 32'd1);
        push1(3'd5, 32'h3F800000, 32'h3F800000, 5'd22);
        flush = 1'b1; in_valid = 1'b1; in_rd = 5'd31;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t6_drop", {31'd0, out_valid}, 32'd0);

        push1(3'd6, 32'h12345678, 32'h87654321, 5'd5);
        @(posedge clk); #1 resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;

        repeat (800) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_op     = 3'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = rand_fp();
            in_rs2    = rand_fp();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
